// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared constants, instruction enum and opcode decode for the JTAG IR/DR
// stage. Imported by jtag_shift_reg and jtag_ir_dr_unit.
//   IR_WIDTH_DEF     : default instruction register length
//   OPC_*_DEF        : default opcodes (BYPASS is always all ones)
//   IR_CAPTURE_PAT   : fixed pattern loaded into the IR on Capture-IR
//   ins_e            : decoded instruction
//   decode_ins()     : opcode -> ins_e, unknown codes fall back to BYPASS
// ---------------------------------------------------------------------------
package jtag_pkg;

  localparam int         IR_WIDTH_DEF   = 4;
  localparam int         IR_MAX_W       = 32;
  localparam logic [3:0] OPC_EXTEST_DEF = 4'h0;
  localparam logic [3:0] OPC_IDCODE_DEF = 4'h1;
  localparam logic [3:0] OPC_SAMPLE_DEF = 4'h2;
  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

  typedef enum logic [1:0] {
    INS_EXTEST,
    INS_SAMPLE,
    INS_IDCODE,
    INS_BYPASS
  } ins_e;

  // Opcodes are zero-extended to IR_MAX_W by the caller. IDCODE only
  // decodes when the IDCODE register is built in; otherwise it is BYPASS.
  function automatic ins_e decode_ins(
    input logic [IR_MAX_W-1:0] ir,
    input logic [IR_MAX_W-1:0] opc_extest,
    input logic [IR_MAX_W-1:0] opc_sample,
    input logic [IR_MAX_W-1:0] opc_idcode,
    input logic [IR_MAX_W-1:0] opc_bypass,
    input logic                idcode_en
  );
    ins_e ins;
    ins = INS_BYPASS;
    if (ir == opc_bypass)                  ins = INS_BYPASS;
    else if (ir == opc_extest)             ins = INS_EXTEST;
    else if (ir == opc_sample)             ins = INS_SAMPLE;
    else if (idcode_en && ir == opc_idcode) ins = INS_IDCODE;
    return ins;
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// ---------------------------------------------------------------------------
// jtag_shift_reg
// Generic JTAG capture/shift register, shifting LSB out towards TDO.
//   i_clk      : TCK
//   i_rst_n    : asynchronous active-low reset (loads CAPTURE_VAL)
//   i_capture  : load CAPTURE_VAL
//   i_shift    : shift right, i_tdi enters at the MSB
//   i_update   : update strobe; while high the register holds (update wins
//                over capture/shift)
//   i_tdi      : serial in
//   o_q        : parallel view of the shift stage
// ---------------------------------------------------------------------------
module jtag_shift_reg
  import jtag_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] CAPTURE_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_capture,
  input  logic             i_shift,
  input  logic             i_update,
  input  logic             i_tdi,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= CAPTURE_VAL;
    end else if (!i_update) begin
      if (i_capture) begin
        r_q <= CAPTURE_VAL;
      end else if (i_shift) begin
        r_q <= {i_tdi, r_q[WIDTH-1:1]};
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jtag_ir_dr_unit.sv
// ---------------------------------------------------------------------------
// jtag_ir_dr_unit
// Serial-path stage behind the TAP controller: instruction register,
// bypass register, optional IDCODE register, instruction decode,
// boundary-scan control qualification and TDO multiplexing.
// Optional feature macro: JTAG_IDCODE_REG_EN
//   defined   : 32-bit IDCODE register, reset instruction IDCODE
//   undefined : no IDCODE register, IDCODE opcode acts as BYPASS,
//               reset instruction BYPASS
// Ports
//   TCK, TRST               : test clock, async active-low reset
//   TDI                     : serial data in
//   clockir/shiftir/updateir: IR strobes from the TAP
//   clockdr/shiftdr/updatedr: DR strobes from the TAP
//   select                  : 1 = IR path on TDO, 0 = DR path
//   bsr_so                  : boundary chain serial out
//   bsr_capture/shift/update: qualified boundary chain controls
//   bsr_mode                : 1 while EXTEST is the active instruction
//   TDO, tdo_oe             : serial out and its enable (negedge TCK)
// ---------------------------------------------------------------------------
module jtag_ir_dr_unit
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_563F,
  parameter logic [IR_WIDTH-1:0] OPC_EXTEST = IR_WIDTH'(OPC_EXTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(OPC_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] OPC_SAMPLE = IR_WIDTH'(OPC_SAMPLE_DEF),
  parameter logic [IR_WIDTH-1:0] OPC_BYPASS = {IR_WIDTH{1'b1}}
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TDI,
  input  logic clockir,
  input  logic shiftir,
  input  logic updateir,
  input  logic clockdr,
  input  logic shiftdr,
  input  logic updatedr,
  input  logic select,
  input  logic bsr_so,
  output logic bsr_capture,
  output logic bsr_shift,
  output logic bsr_update,
  output logic bsr_mode,
  output logic TDO,
  output logic tdo_oe
);

  localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(IR_CAPTURE_PAT);

`ifdef JTAG_IDCODE_REG_EN
  localparam logic                IDCODE_EN = 1'b1;
  localparam logic [IR_WIDTH-1:0] IR_RST    = OPC_IDCODE;
`else
  localparam logic                IDCODE_EN = 1'b0;
  localparam logic [IR_WIDTH-1:0] IR_RST    = OPC_BYPASS;
`endif

  logic [IR_WIDTH-1:0] w_ir_shift;
  logic [IR_WIDTH-1:0] r_ir_reg;
  logic                r_bypass;
  logic                r_bsr_mode;
  logic                r_tdo;
  logic                r_tdo_oe;
  ins_e                w_ins;
  ins_e                w_ins_next;
  logic                w_ir_cap;
  logic                w_ir_sh;
  logic                w_dr_cap;
  logic                w_dr_sh;
  logic                w_bsr_sel;
  logic                w_id_so;
  logic                w_tdo_oe;
  logic                w_tdo_mux;

  assign w_ir_cap = clockir & ~shiftir;
  assign w_ir_sh  = clockir &  shiftir;
  assign w_dr_cap = clockdr & ~shiftdr;
  assign w_dr_sh  = clockdr &  shiftdr;

  // Instruction register: shift stage in the sub-module, update stage here
  jtag_shift_reg #(
    .WIDTH      (IR_WIDTH),
    .CAPTURE_VAL(IR_CAP)
  ) u_ir_shift (
    .i_clk    (TCK),
    .i_rst_n  (TRST),
    .i_capture(w_ir_cap),
    .i_shift  (w_ir_sh),
    .i_update (updateir),
    .i_tdi    (TDI),
    .o_q      (w_ir_shift)
  );

  assign w_ins = decode_ins(IR_MAX_W'(r_ir_reg), IR_MAX_W'(OPC_EXTEST),
                            IR_MAX_W'(OPC_SAMPLE), IR_MAX_W'(OPC_IDCODE),
                            IR_MAX_W'(OPC_BYPASS), IDCODE_EN);

  // Decode of the value about to be loaded, so bsr_mode lands on the same
  // edge as the instruction itself.
  assign w_ins_next = decode_ins(IR_MAX_W'(w_ir_shift), IR_MAX_W'(OPC_EXTEST),
                                 IR_MAX_W'(OPC_SAMPLE), IR_MAX_W'(OPC_IDCODE),
                                 IR_MAX_W'(OPC_BYPASS), IDCODE_EN);

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_ir_reg   <= IR_RST;
      r_bsr_mode <= 1'b0;
    end else if (updateir) begin
      r_ir_reg   <= w_ir_shift;
      r_bsr_mode <= (w_ins_next == INS_EXTEST);
    end
  end

  // Bypass register: captures 0, shifts TDI
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_bypass <= 1'b0;
    end else if (clockdr && w_ins == INS_BYPASS) begin
      r_bypass <= shiftdr & TDI;
    end
  end

`ifdef JTAG_IDCODE_REG_EN
  logic [31:0] w_id_q;
  logic [30:0] w_unused_id_hi;

  jtag_shift_reg #(
    .WIDTH      (32),
    .CAPTURE_VAL(IDCODE_VAL)
  ) u_id_shift (
    .i_clk    (TCK),
    .i_rst_n  (TRST),
    .i_capture(w_dr_cap & (w_ins == INS_IDCODE)),
    .i_shift  (w_dr_sh  & (w_ins == INS_IDCODE)),
    .i_update (1'b0),
    .i_tdi    (TDI),
    .o_q      (w_id_q)
  );

  assign w_id_so        = w_id_q[0];
  assign w_unused_id_hi = w_id_q[31:1];
`else
  logic [31:0] w_unused_idcode;

  assign w_id_so         = 1'b0;
  assign w_unused_idcode = IDCODE_VAL;
`endif

  // Boundary chain controls are combinational and gated by the decode
  assign w_bsr_sel   = (w_ins == INS_EXTEST) || (w_ins == INS_SAMPLE);
  assign bsr_capture = w_bsr_sel & w_dr_cap;
  assign bsr_shift   = w_bsr_sel & w_dr_sh;
  assign bsr_update  = w_bsr_sel & updatedr;
  assign bsr_mode    = r_bsr_mode;

  always_comb begin
    w_tdo_mux = r_bypass;
    if (select) begin
      w_tdo_mux = w_ir_shift[0];
    end else begin
      case (w_ins)
        INS_EXTEST, INS_SAMPLE: w_tdo_mux = bsr_so;
        INS_IDCODE:             w_tdo_mux = w_id_so;
        default:                w_tdo_mux = r_bypass;
      endcase
    end
  end

  assign w_tdo_oe = w_ir_sh | w_dr_sh;

  // TDO launches on the falling edge; it holds while not shifting
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo_oe <= w_tdo_oe;
      if (w_tdo_oe) begin
        r_tdo <= w_tdo_mux;
      end
    end
  end

  assign TDO    = r_tdo;
  assign tdo_oe = r_tdo_oe;

endmodule

// File: tb/tb_jtag_ir_dr_unit.sv
// ---------------------------------------------------------------------------
// tb_jtag_ir_dr_unit
// Directed bench for jtag_ir_dr_unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit after the falling edge.
// Expected values for the reset instruction follow JTAG_IDCODE_REG_EN.
// ---------------------------------------------------------------------------
module tb_jtag_ir_dr_unit;

  logic TCK = 1'b0;
  logic TRST, TDI, clockir, shiftir, updateir, clockdr, shiftdr, updatedr;
  logic select, bsr_so;
  logic bsr_capture, bsr_shift, bsr_update, bsr_mode, TDO, tdo_oe;

  int n_chk  = 0;
  int n_fail = 0;

  jtag_ir_dr_unit dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TDI        (TDI),
    .clockir    (clockir),
    .shiftir    (shiftir),
    .updateir   (updateir),
    .clockdr    (clockdr),
    .shiftdr    (shiftdr),
    .updatedr   (updatedr),
    .select     (select),
    .bsr_so     (bsr_so),
    .bsr_capture(bsr_capture),
    .bsr_shift  (bsr_shift),
    .bsr_update (bsr_update),
    .bsr_mode   (bsr_mode),
    .TDO        (TDO),
    .tdo_oe     (tdo_oe)
  );

  always #5 TCK = ~TCK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK cycle with the inputs as currently set
  task automatic tick(output logic tdo_s, output logic oe_s, output logic [2:0] bsr_s);
    @(negedge TCK);
    #1;
    tdo_s = TDO;
    oe_s  = tdo_oe;
    bsr_s = {bsr_capture, bsr_shift, bsr_update};
    @(posedge TCK);
    #1;
  endtask

  // Capture-IR, 4 shifts (LSB first), Update-IR
  task automatic ir_scan(input logic [3:0] op, output logic [3:0] tdo_v, output logic oe_all);
    logic t, oe;
    logic [2:0] b;
    select = 1'b1; clockir = 1'b1; shiftir = 1'b0;
    tick(t, oe, b);
    shiftir = 1'b1;
    oe_all  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDI = op[i];
      tick(t, oe, b);
      tdo_v[i] = t;
      oe_all   = oe_all & oe;
    end
    clockir = 1'b0; shiftir = 1'b0; TDI = 1'b0; updateir = 1'b1;
    tick(t, oe, b);
    updateir = 1'b0; select = 1'b0;
  endtask

  // Capture-DR, n shifts, Update-DR; seen = {capture, shift, update} ever high
  task automatic dr_scan(input int n, input logic [31:0] tdi_v, input logic [31:0] bso_v,
                         output logic [31:0] tdo_v, output logic [2:0] seen);
    logic t, oe;
    logic [2:0] b;
    tdo_v = '0;
    seen  = '0;
    select = 1'b0; clockdr = 1'b1; shiftdr = 1'b0;
    tick(t, oe, b);
    seen[2] = b[2];
    shiftdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      TDI    = tdi_v[i];
      bsr_so = bso_v[i];
      tick(t, oe, b);
      tdo_v[i] = t;
      seen[1]  = seen[1] | b[1];
      seen[2]  = seen[2] | b[2];
    end
    clockdr = 1'b0; shiftdr = 1'b0; TDI = 1'b0; bsr_so = 1'b0; updatedr = 1'b1;
    tick(t, oe, b);
    seen[0] = b[0];
    updatedr = 1'b0;
  endtask

  // Scan that identifies the reset instruction from its DR behaviour
  task automatic chk_reset_ins(input string tag);
    logic [31:0] v;
    logic [2:0]  s;
`ifdef JTAG_IDCODE_REG_EN
    dr_scan(32, 32'h0, 32'h0, v, s);
    chk({tag, "_idcode"}, v, 32'h1000_563F);
`else
    dr_scan(8, 32'hA5, 32'h0, v, s);
    chk({tag, "_bypass"}, v, 32'h0000_004A);
`endif
    chk({tag, "_bsr_seen"}, {29'd0, s}, 32'd0);
  endtask

  logic [3:0]  ir_tdo;
  logic        ir_oe;
  logic [31:0] dr_tdo;
  logic [2:0]  seen;
  logic        t_s, oe_s;
  logic [2:0]  b_s;

  initial begin
    TRST = 1'b0; TDI = 1'b0; clockir = 1'b0; shiftir = 1'b0; updateir = 1'b0;
    clockdr = 1'b0; shiftdr = 1'b0; updatedr = 1'b0; select = 1'b0; bsr_so = 1'b0;

    // Reset state
    #2;
    chk("rst_tdo", {31'd0, TDO}, 32'd0);
    chk("rst_tdo_oe", {31'd0, tdo_oe}, 32'd0);
    chk("rst_bsr_mode", {31'd0, bsr_mode}, 32'd0);
    chk("rst_bsr_ctl", {29'd0, bsr_capture, bsr_shift, bsr_update}, 32'd0);
    @(posedge TCK);
    #1;
    TRST = 1'b1;
    chk_reset_ins("rst_ins");
    chk("rst_oe_idle", {31'd0, tdo_oe}, 32'd0);

    // IR load of EXTEST: captured 0001 shifts out LSB first
    ir_scan(4'h0, ir_tdo, ir_oe);
    chk("ir_tdo_capture", {28'd0, ir_tdo}, 32'h1);
    chk("ir_tdo_oe", {31'd0, ir_oe}, 32'd1);
    chk("extest_mode", {31'd0, bsr_mode}, 32'd1);
    dr_scan(4, 32'h0, 32'h5, dr_tdo, seen);
    chk("extest_tdo", dr_tdo, 32'h5);
    chk("extest_seen", {29'd0, seen}, 32'h7);

    // BYPASS: one-edge delay behind a captured 0
    ir_scan(4'hF, ir_tdo, ir_oe);
    chk("byp_ir_tdo", {28'd0, ir_tdo}, 32'h1);
    chk("byp_mode", {31'd0, bsr_mode}, 32'd0);
    dr_scan(4, 32'hD, 32'h0, dr_tdo, seen);
    chk("byp_tdo", dr_tdo, 32'hA);
    chk("byp_tdo_hold", {31'd0, TDO}, 32'd1);

    // Illegal opcode acts as BYPASS, boundary chain untouched
    ir_scan(4'h7, ir_tdo, ir_oe);
    dr_scan(4, 32'h6, 32'hF, dr_tdo, seen);
    chk("ill_tdo", dr_tdo, 32'hC);
    chk("ill_seen", {29'd0, seen}, 32'd0);

    // SAMPLE/PRELOAD: TDO follows bsr_so, not in EXTEST mode
    ir_scan(4'h2, ir_tdo, ir_oe);
    chk("smp_mode", {31'd0, bsr_mode}, 32'd0);
    dr_scan(4, 32'h0, 32'hB, dr_tdo, seen);
    chk("smp_tdo", dr_tdo, 32'hB);
    chk("smp_seen", {29'd0, seen}, 32'h7);

    // IDCODE opcode: IDCODE register when built in, else BYPASS
    ir_scan(4'h1, ir_tdo, ir_oe);
    dr_scan(8, 32'hA5, 32'h0, dr_tdo, seen);
`ifdef JTAG_IDCODE_REG_EN
    chk("idc_tdo", dr_tdo, 32'h3F);
`else
    chk("idc_tdo", dr_tdo, 32'h4A);
`endif

    // Update wins over a coincident shift: shift in SAMPLE, then update
    // with clockir/shiftir still high and TDI=1; a shift would give 4'h9.
    select = 1'b1; clockir = 1'b1; shiftir = 1'b0;
    tick(t_s, oe_s, b_s);
    shiftir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDI = (i == 1);
      tick(t_s, oe_s, b_s);
    end
    TDI = 1'b1; updateir = 1'b1;
    tick(t_s, oe_s, b_s);
    clockir = 1'b0; shiftir = 1'b0; TDI = 1'b0;
    tick(t_s, oe_s, b_s);
    updateir = 1'b0; select = 1'b0;
    dr_scan(4, 32'h0, 32'h9, dr_tdo, seen);
    chk("upd_prio_tdo", dr_tdo, 32'h9);
    chk("upd_prio_seen", {29'd0, seen}, 32'h7);

    // TRST during an IR shift: back to reset, nothing updated
    ir_scan(4'h0, ir_tdo, ir_oe);
    chk("trst_pre_mode", {31'd0, bsr_mode}, 32'd1);
    select = 1'b1; clockir = 1'b1; shiftir = 1'b0;
    tick(t_s, oe_s, b_s);
    shiftir = 1'b1; TDI = 1'b1;
    tick(t_s, oe_s, b_s);
    tick(t_s, oe_s, b_s);
    #2;
    TRST = 1'b0;
    #1;
    chk("trst_mode", {31'd0, bsr_mode}, 32'd0);
    chk("trst_tdo", {31'd0, TDO}, 32'd0);
    chk("trst_oe", {31'd0, tdo_oe}, 32'd0);
    chk("trst_bsr_update", {31'd0, bsr_update}, 32'd0);
    clockir = 1'b0; shiftir = 1'b0; TDI = 1'b0; select = 1'b0;
    @(negedge TCK);
    #1;
    TRST = 1'b1;
    @(posedge TCK);
    #1;
    chk_reset_ins("trst_ins");
    ir_scan(4'hF, ir_tdo, ir_oe);
    chk("trst_ir_capture", {28'd0, ir_tdo}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
